// File: rtl/wb_writeback_source.sv
// Writeback stage of the 3-stage RV32 pipeline: X->W register, load alignment,
// regfile write-port drive and retired-instruction counter.
module wb_writeback_source #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush_x,
   input  logic             valid_x,
   input  logic [6:0]       opcode_x,
   input  logic [2:0]       funct3_x,
   input  logic [4:0]       rd_x,
   input  logic [XLEN-1:0]  alu_x,
   input  logic [XLEN-1:0]  pc4_x,
   input  logic [XLEN-1:0]  dmem_rdata,
   output logic [4:0]       rd_w,
   output logic             rwe_w,
   output logic [XLEN-1:0]  wb_data,
   output logic             valid_w,
   output logic [CNT_W-1:0] instret
);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_OP    = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      ACTIVE = 2'd1,
      HELD   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              valid_q;
   logic [6:0]        op_q;
   logic [2:0]        f3_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   alu_q;
   logic [XLEN-1:0]   pc4_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              capture;

   assign capture = valid_x && !flush_x;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         op_q    <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         alu_q   <= '0;
         pc4_q   <= '0;
      end else if (!stall) begin
         if (capture) begin
            valid_q <= 1'b1;
            op_q    <= opcode_x;
            f3_q    <= funct3_x;
            rd_q    <= rd_x;
            alu_q   <= alu_x;
            pc4_q   <= pc4_x;
         end else begin
            valid_q <= 1'b0;
            op_q    <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
            pc4_q   <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (valid_q && !stall) cnt_q <= cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: begin
            if (!stall && capture) state_d = ACTIVE;
         end
         ACTIVE, HELD: begin
            if (stall)        state_d = HELD;
            else if (capture) state_d = ACTIVE;
            else              state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   logic            writes_rd;
   logic [7:0]      lane_b;
   logic [15:0]     lane_h;
   logic [XLEN-1:0] load_val;

   always_comb begin
      writes_rd = 1'b0;
      unique case (op_q)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
         OP_OP, OP_IMM, OP_LOAD: writes_rd = 1'b1;
         default:                writes_rd = 1'b0;
      endcase
   end

   // Little-endian lanes; funct3[2] selects zero extension.
   assign lane_b = dmem_rdata[{alu_q[1:0], 3'b000} +: 8];
   assign lane_h = dmem_rdata[{alu_q[1], 4'b0000} +: 16];

   always_comb begin
      load_val = '0;
      unique case (f3_q)
         3'b000:  load_val = {{(XLEN-8){lane_b[7]}}, lane_b};
         3'b100:  load_val = {{(XLEN-8){1'b0}}, lane_b};
         3'b001:  load_val = {{(XLEN-16){lane_h[15]}}, lane_h};
         3'b101:  load_val = {{(XLEN-16){1'b0}}, lane_h};
         3'b010:  load_val = dmem_rdata;
         default: load_val = '0;
      endcase
   end

   always_comb begin
      wb_data = '0;
      if (valid_q) begin
         unique case (op_q)
            OP_JAL, OP_JALR: wb_data = pc4_q;
            OP_LOAD:         wb_data = load_val;
            default:         wb_data = alu_q;
         endcase
      end
   end

   assign rwe_w   = valid_q && (rd_q != 5'd0) && writes_rd;
   assign rd_w    = rd_q;
   assign valid_w = valid_q;
   assign instret = cnt_q;

endmodule
